// File: rtl/cmp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, result codes, index sizing.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_EQ   = 2'd1;
  localparam logic [1:0] RES_GT   = 2'd2;
  localparam logic [1:0] RES_LT   = 2'd3;

  // A single-chunk scan still needs a 1-bit index register.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational CHUNK-bit unsigned compare; eq from per-bit XNOR, gt from an MSB-first priority chain.
module cmp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic             o_eq,
  output logic             o_gt
);

  logic [CHUNK-1:0] w_same;
  logic             w_eq_acc;
  logic             w_gt_acc;

  always_comb begin
    w_same   = i_a ~^ i_b;
    w_eq_acc = 1'b1;
    w_gt_acc = 1'b0;
    // The first differing bit from the top decides; lower bits are masked once w_eq_acc drops.
    for (int i = CHUNK - 1; i >= 0; i--) begin
      w_gt_acc = w_gt_acc | (w_eq_acc & i_a[i] & ~i_b[i]);
      w_eq_acc = w_eq_acc & w_same[i];
    end
  end

  assign o_eq = w_eq_acc;
  assign o_gt = w_gt_acc;

endmodule

// File: rtl/seq_magnitude_comparator.sv
// WIDTH-bit compare, CHUNK bits/cycle MSB-first with early exit: result 1..NCHUNK cycles after accept, held until out_ready.
// Accepts only in IDLE; SIGNED_CMP_EN selects two's-complement operands (sign bits inverted on the top chunk).
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic             a_lt_b,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = idx_width(NCHUNK);
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("seq_magnitude_comparator: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDXW-1:0]  r_idx;
  logic [1:0]       r_res;
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic             w_chunk_eq;
  logic             w_chunk_gt;
  logic [1:0]       w_scan_res;

  always_comb begin
    w_ca = r_a[int'(r_idx) * CHUNK +: CHUNK];
    w_cb = r_b[int'(r_idx) * CHUNK +: CHUNK];
`ifdef SIGNED_CMP_EN
    // Flipping both sign bits maps two's complement onto unsigned order.
    if (r_idx == IDX_TOP) begin
      w_ca[CHUNK-1] = ~w_ca[CHUNK-1];
      w_cb[CHUNK-1] = ~w_cb[CHUNK-1];
    end
`endif
  end

  cmp_chunk #(
    .CHUNK (CHUNK)
  ) u_cmp_chunk (
    .i_a  (w_ca),
    .i_b  (w_cb),
    .o_eq (w_chunk_eq),
    .o_gt (w_chunk_gt)
  );

  assign w_scan_res = !w_chunk_eq ? (w_chunk_gt ? RES_GT : RES_LT) : RES_EQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = SCAN;
      SCAN:    if (!w_chunk_eq || r_idx == '0) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_res <= RES_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_idx <= IDX_TOP;
          end
        end
        SCAN: begin
          if (w_state_nxt == DONE) begin
            r_res <= w_scan_res;
          end else begin
            r_idx <= r_idx - IDXW'(1);
          end
        end
        DONE: begin
          if (out_ready) r_res <= RES_NONE;
        end
        default: r_res <= RES_NONE;
      endcase
    end
  end

  // r_res is only non-zero while in DONE, so the flags are one-hot there and zero elsewhere.
  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign a_eq_b    = (r_res == RES_EQ);
  assign a_gt_b    = (r_res == RES_GT);
  assign a_lt_b    = (r_res == RES_LT);

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Bench: three comparators (CHUNK 4, 1, 16) driven with directed and random pairs, scored against a
// behavioural compare; honours SIGNED_CMP_EN.
module tb_seq_magnitude_comparator;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid  [3];
  logic          in_ready  [3];
  logic [W-1:0]  op_a      [3];
  logic [W-1:0]  op_b      [3];
  logic          out_valid [3];
  logic          out_ready [3];
  logic          a_eq_b    [3];
  logic          a_gt_b    [3];
  logic          a_lt_b    [3];
  logic          busy      [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit rnd_rdy = 0;

  typedef struct {
    int         inst;
    logic [2:0] flags;  // {eq, gt, lt}
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  exp_t cur[3];
  bit   prev_vld[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CH = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    seq_magnitude_comparator #(
      .WIDTH (W),
      .CHUNK (CH)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .a         (op_a[g]),
      .b         (op_b[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .a_eq_b    (a_eq_b[g]),
      .a_gt_b    (a_gt_b[g]),
      .a_lt_b    (a_lt_b[g]),
      .busy      (busy[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int chunk_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 16);
  endfunction

  // Reference: plain integer compare; latency = number of chunks down to the highest differing bit.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input int ch,
                                output logic [2:0] f, output int k);
    int sa;
    int sb_v;
    int msb;
    logic [W-1:0] d;
    int n;
    n = W / ch;
`ifdef SIGNED_CMP_EN
    sa   = $signed(av);
    sb_v = $signed(bv);
`else
    sa   = int'(av);
    sb_v = int'(bv);
`endif
    f = (sa == sb_v) ? 3'b100 : ((sa > sb_v) ? 3'b010 : 3'b001);
    d = av ^ bv;
    msb = -1;
    for (int j = 0; j < W; j++) if (d[j]) msb = j;
    k = (msb < 0) ? n : n - (msb / ch);
  endfunction

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h (cycle %0d)", nm, inst, act, exp, cyc);
    end
  endtask

  task automatic issue(input int i, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [2:0] ef, input int el);
    exp_t e;
    int guard;
    guard = 0;
    @(posedge clk); #1;
    in_valid[i] = 1'b1;
    op_a[i] = av;
    op_b[i] = bv;
    forever begin
      @(negedge clk);
      if (in_ready[i]) break;
      guard++;
      if (guard > 500) begin
        checks++;
        errors++;
        $display("FAIL accept timeout inst%0d: in_ready stayed 0, required 1", i);
        in_valid[i] = 1'b0;
        return;
      end
    end
    e.inst = i; e.flags = ef; e.lat = el; e.acc = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    op_a[i] = W'($urandom);
    op_b[i] = W'($urandom);
  endtask

  task automatic issue_model(input int i, input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [2:0] f;
    int k;
    model(av, bv, chunk_of(i), f, k);
    issue(i, av, bv, f, k);
  endtask

  task automatic drain(input int budget);
    int t;
    t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard drained", 0, sb.size(), 0);
  endtask

  task automatic run_random(input int i, input int n);
    logic [W-1:0] av;
    logic [W-1:0] bv;
    for (int t = 0; t < n; t++) begin
      av = W'($urandom);
      case ($urandom_range(0, 3))
        0:       bv = av;
        1:       bv = av ^ (16'h0001 << $urandom_range(0, 15));
        default: bv = W'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      issue_model(i, av, bv);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) begin
      for (int i = 0; i < 3; i++) out_ready[i] = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the matching expectation when a result appears, then checks flags every DONE cycle.
  always @(negedge clk) begin
    logic [2:0] got;
    int idx;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) prev_vld[i] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        got = {a_eq_b[i], a_gt_b[i], a_lt_b[i]};
        if (!out_valid[i]) begin
          chk("flags zero when not valid", i, got, 0);
          prev_vld[i] = 1'b0;
        end else begin
          if (!prev_vld[i]) begin
            idx = -1;
            foreach (sb[j]) if (idx < 0 && sb[j].inst == i) idx = j;
            if (idx < 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected result inst%0d: got out_valid=1 flags=%b, required no result", i, got);
              cur[i].flags = 3'b000;
            end else begin
              cur[i] = sb[idx];
              sb.delete(idx);
              chk("latency", i, cyc - cur[i].acc, cur[i].lat);
            end
          end
          chk("result flags", i, got, cur[i].flags);
          chk("in_ready low while valid", i, in_ready[i], 0);
          prev_vld[i] = !out_ready[i];
        end
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      op_a[i]      = '0;
      op_b[i]      = '0;
      out_ready[i] = 1'b1;
    end
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset out_valid", i, out_valid[i], 0);
      chk("reset flags", i, {a_eq_b[i], a_gt_b[i], a_lt_b[i]}, 0);
      chk("reset busy", i, busy[i], 0);
      chk("reset in_ready", i, in_ready[i], 1);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    issue(0, 16'h1234, 16'h1234, 3'b100, 4);
`ifdef SIGNED_CMP_EN
    issue(0, 16'h8000, 16'h7FFF, 3'b001, 1);
`else
    issue(0, 16'h8000, 16'h7FFF, 3'b010, 1);
`endif
    issue(0, 16'h1230, 16'h1231, 3'b001, 4);
    issue(0, 16'h1300, 16'h12FF, 3'b010, 2);
    drain(50);

    // Output stall: result held with out_ready low, competing input not taken until after handshake.
    out_ready[0] = 1'b0;
    issue(0, 16'h1300, 16'h12FF, 3'b010, 2);
    guard = 0;
    while (!out_valid[0] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b1;
    op_a[0] = 16'h1230;
    op_b[0] = 16'h1231;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      chk("stall out_valid", 0, out_valid[0], 1);
      chk("stall flags", 0, {a_eq_b[0], a_gt_b[0], a_lt_b[0]}, 3'b010);
      chk("stall in_ready", 0, in_ready[0], 0);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("handshake cycle in_ready", 0, in_ready[0], 0);
    @(negedge clk);
    chk("post-handshake out_valid", 0, out_valid[0], 0);
    chk("post-handshake in_ready", 0, in_ready[0], 1);
    begin
      exp_t e;
      e.inst = 0; e.flags = 3'b001; e.lat = 4; e.acc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    drain(50);

    // Reset in the middle of a scan: outputs return to reset values at once, the pair is discarded.
    @(posedge clk); #1;
    in_valid[0] = 1'b1;
    op_a[0] = 16'h5555;
    op_b[0] = 16'h5555;
    @(negedge clk);
    chk("abort pair accepted", 0, in_ready[0], 1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    chk("mid-scan busy", 0, busy[0], 1);
    rst_n = 1'b0;
    #1;
    chk("async reset busy", 0, busy[0], 0);
    chk("async reset in_ready", 0, in_ready[0], 1);
    chk("async reset out_valid", 0, out_valid[0], 0);
    chk("async reset flags", 0, {a_eq_b[0], a_gt_b[0], a_lt_b[0]}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk("aborted pair never presented", 0, out_valid[0], 0);
    end

    rnd_rdy = 1'b1;
    fork
      run_random(0, 1000);
      run_random(1, 1000);
      run_random(2, 1000);
    join
    rnd_rdy = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) out_ready[i] = 1'b1;
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

endmodule
